// File: rtl/membuf_writeback_dma.sv
// DMA read-port master: streams cfg_len words from an on-chip buffer into a
// valid/ready stream framed by m_tlast, issuing reads only against FIFO credit.
module membuf_writeback_dma #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [1:0]       cfg_src,
    input  logic [31:0]      cfg_base,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      mem_raddr,
    output logic             mem_ren,
    output logic [1:0]       mem_rsrc,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_rvalid,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW:0]   DEPTH_V     = (CW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BURST_LAST  = BW'(BURST_LEN - 1);
    localparam logic [1:0]    SRC_ILLEGAL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        src_q, src_d;
    logic [31:0]       base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  sent_q, sent_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [31:0]       raddr_q, raddr_d;
    logic              inflight_q;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;

    logic              ren;
    logic              hs;
    logic              push;
    logic              flush;
    logic              last_beat;
    logic              credit_ok;
    logic [CW:0]       occupancy;
    logic [31:0]       addr_now;

    // Credit counts both queued words and the read still in flight, so a
    // returning word always has a free slot.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign credit_ok = occupancy < DEPTH_V;
    assign addr_now  = base_q + 32'(issued_q);

    assign busy      = (state_q != S_IDLE);
    assign ren       = (state_q == S_RUN) && !cfg_abort && (issued_q < len_q) && credit_ok;
    assign m_tvalid  = (count_q != '0);
    assign hs        = m_tvalid && m_tready;
    assign push      = mem_rvalid && busy;
    assign last_beat = ((sent_q + LEN_W'(1)) == len_q);

    assign mem_ren   = ren;
    assign mem_raddr = ren ? addr_now : raddr_q;
    assign mem_rsrc  = src_q;
    assign m_tdata   = m_tvalid ? fifo_mem_q[rptr_q] : '0;
    assign m_tlast   = m_tvalid && ((bcnt_q == BURST_LAST) || last_beat);
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = ren ? issued_q + LEN_W'(1) : issued_q;
        sent_d   = hs ? sent_q + LEN_W'(1) : sent_q;
        bcnt_d   = bcnt_q;
        raddr_d  = ren ? addr_now : raddr_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        flush    = 1'b0;

        if (hs) begin
            bcnt_d = (bcnt_q == BURST_LAST) ? '0 : bcnt_q + BW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    if ((cfg_len == '0) || (cfg_src == SRC_ILLEGAL)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        src_d    = cfg_src;
                        base_d   = cfg_base;
                        len_d    = cfg_len;
                        issued_d = '0;
                        sent_d   = '0;
                        bcnt_d   = '0;
                    end
                end
            end
            S_RUN, S_DRAIN: begin
                if (cfg_abort) begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (hs && last_beat) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if ((state_q == S_RUN) && (issued_q == len_q)) begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            bcnt_q     <= '0;
            raddr_q    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            bcnt_q     <= bcnt_d;
            raddr_q    <= raddr_d;
            inflight_q <= ren;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Flush on abort overrides any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (hs)   rptr_q <= rptr_q + PW'(1);
            case ({push, hs})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_mem_q[wptr_q] <= mem_rdata;
        end
    end

endmodule
